// File: rtl/scan_disp_n.sv
// scan_disp_n: time-multiplexed NDIG-digit 7-segment scan driver.
// Inputs: clk, rstn (async low), enable, digits, dp_in, blank, blink_mask,
//         nlit (active digit count), lzs (zero suppress), duty (brightness).
// Outputs: dig (one-hot digit select, polarity by DIG_LOW), seg (dp,g..a),
//          frame_tick (pulse after the last slot of each frame).
module scan_disp_n #(
    parameter int NDIG     = 8,
    parameter int DIV      = 50000,
    parameter int BLINK_FR = 64,
    parameter int DIG_LOW  = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic [4*NDIG-1:0]          digits,
    input  logic [NDIG-1:0]            dp_in,
    input  logic [NDIG-1:0]            blank,
    input  logic [NDIG-1:0]            blink_mask,
    input  logic [$clog2(NDIG+1)-1:0]  nlit,
    input  logic                       lzs,
    input  logic [3:0]                 duty,
    output logic [NDIG-1:0]            dig,
    output logic [7:0]                 seg,
    output logic                       frame_tick
);

    localparam int NW = $clog2(NDIG + 1);
    localparam int IW = $clog2(NDIG);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam int CW = PW + 5;

    localparam logic [NW-1:0]   L_NDIG = NW'(NDIG);
    localparam logic [PW-1:0]   L_PMAX = PW'(DIV - 1);
    localparam logic [FW-1:0]   L_FMAX = FW'(BLINK_FR - 1);
    localparam logic [CW-1:0]   L_DIV  = CW'(DIV);
    localparam logic [NDIG-1:0] L_DOFF = (DIG_LOW != 0) ? {NDIG{1'b1}}
                                                        : {NDIG{1'b0}};

    logic [PW-1:0]   r_pre;
    logic [IW-1:0]   r_idx;
    logic [FW-1:0]   r_fcnt;
    logic            r_bph;
    logic [NDIG-1:0] r_dig;
    logic [7:0]      r_seg;
    logic            r_ftick;

    logic [NW-1:0]   w_nact;
    logic [NW-1:0]   w_last;
    logic [NW-1:0]   w_idx_ext;
    logic [NDIG-1:0] w_pz;
    logic [3:0]      w_val;
    logic            w_supp;
    logic            w_inact;
    logic [CW-1:0]   w_pre16;
    logic [CW-1:0]   w_lim;
    logic            w_on;
    logic            w_lit;
    logic [NDIG-1:0] w_sel;
    logic            w_slot_end;
    logic            w_frame_end;

    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        logic [6:0] g;
        g = 7'h00;
        unique case (v)
            4'h0: g = 7'h3f;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5b;
            4'h3: g = 7'h4f;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6d;
            4'h6: g = 7'h7d;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7f;
            4'h9: g = 7'h6f;
            4'ha: g = 7'h77;
            4'hb: g = 7'h7c;
            4'hc: g = 7'h39;
            4'hd: g = 7'h5e;
            4'he: g = 7'h79;
            4'hf: g = 7'h71;
        endcase
        return g;
    endfunction

    // Out-of-range counts fall back to the full display.
    assign w_nact    = (nlit == '0 || nlit > L_NDIG) ? L_NDIG : nlit;
    assign w_last    = w_nact - NW'(1);
    assign w_idx_ext = NW'(r_idx);

    // w_pz[i]: digits 0..i are all zero.
    always_comb begin
        logic v_z;
        v_z  = 1'b1;
        w_pz = '0;
        for (int i = 0; i < NDIG; i++) begin
            v_z     = v_z & (digits[4*i +: 4] == 4'h0);
            w_pz[i] = v_z;
        end
    end

    assign w_val   = digits[{r_idx, 2'b00} +: 4];
    assign w_supp  = lzs && w_pz[r_idx] && (w_idx_ext < w_last);
    assign w_inact = w_idx_ext < w_nact;

    // Lit window: pre*16 < (duty+1)*DIV, sized so nothing truncates.
    assign w_pre16 = CW'({r_pre, 4'b0000});
    assign w_lim   = (CW'(duty) + CW'(1)) * L_DIV;
    assign w_on    = w_pre16 < w_lim;

    assign w_lit = enable && w_inact && !blank[r_idx]
                 && !(blink_mask[r_idx] && r_bph)
                 && !w_supp && w_on;

    assign w_sel       = NDIG'(1) << r_idx;
    assign w_slot_end  = (r_pre == L_PMAX);
    // ">=" also catches an idx left beyond a freshly reduced nlit.
    assign w_frame_end = w_slot_end && (w_idx_ext >= w_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_bph   <= 1'b0;
            r_dig   <= L_DOFF;
            r_seg   <= 8'h00;
            r_ftick <= 1'b0;
        end else if (!enable) begin
            r_dig   <= L_DOFF;
            r_seg   <= 8'h00;
            r_ftick <= 1'b0;
        end else begin
            r_dig   <= w_lit ? (w_sel ^ L_DOFF) : L_DOFF;
            r_seg   <= w_lit ? {dp_in[r_idx], f_glyph(w_val)} : 8'h00;
            r_ftick <= w_frame_end;
            if (w_slot_end) begin
                r_pre <= '0;
                if (w_frame_end) begin
                    r_idx <= '0;
                    if (r_fcnt == L_FMAX) begin
                        r_fcnt <= '0;
                        r_bph  <= ~r_bph;
                    end else begin
                        r_fcnt <= r_fcnt + FW'(1);
                    end
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign dig        = r_dig;
    assign seg        = r_seg;
    assign frame_tick = r_ftick;

endmodule

// File: tb/tb_scan_disp_n.sv
// tb_scan_disp_n: directed bench for scan_disp_n with a cycle model
// feeding an expected-output queue, plus constant checks per scenario.
module tb_scan_disp_n;

    localparam int NDIG = 8;
    localparam int DIV  = 16;
    localparam int BFR  = 2;

    localparam logic [6:0] GLY [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] digits;
    logic [7:0]  dp_in;
    logic [7:0]  blank;
    logic [7:0]  blink_mask;
    logic [3:0]  nlit;
    logic        lzs;
    logic [3:0]  duty;
    logic [7:0]  dig;
    logic [7:0]  seg;
    logic        frame_tick;

    typedef struct {
        logic [7:0] d;
        logic [7:0] s;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int   m_pre, m_idx, m_fcnt;
    bit   m_bph;

    scan_disp_n #(
        .NDIG(NDIG), .DIV(DIV), .BLINK_FR(BFR), .DIG_LOW(1)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .digits(digits),
        .dp_in(dp_in), .blank(blank), .blink_mask(blink_mask),
        .nlit(nlit), .lzs(lzs), .duty(duty), .dig(dig), .seg(seg),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre  = 0;
        m_idx  = 0;
        m_fcnt = 0;
        m_bph  = 0;
    endtask

    // Expected registered outputs for the coming edge; advances the model.
    task automatic model_edge(output exp_t e);
        int nact;
        bit lit, sup, allz;
        logic [3:0] v;
        e.d = 8'hFF;
        e.s = 8'h00;
        e.f = 1'b0;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (!enable) return;
        nact = (nlit == 0 || int'(nlit) > NDIG) ? NDIG : int'(nlit);
        allz = 1;
        for (int j = 0; j <= m_idx; j++)
            if (digits[j*4 +: 4] != 4'h0) allz = 0;
        sup = lzs && (m_idx < nact - 1) && allz;
        lit = (m_idx < nact) && !blank[m_idx]
            && !(blink_mask[m_idx] && m_bph) && !sup
            && (m_pre * 16 < (int'(duty) + 1) * DIV);
        if (lit) begin
            v   = digits[m_idx*4 +: 4];
            e.d = ~(8'h01 << m_idx);
            e.s = {dp_in[m_idx], GLY[v]};
        end
        if (m_pre == DIV - 1) begin
            m_pre = 0;
            if (m_idx >= nact - 1) begin
                m_idx = 0;
                e.f   = 1'b1;
                if (m_fcnt == BFR - 1) begin
                    m_fcnt = 0;
                    m_bph  = !m_bph;
                end else begin
                    m_fcnt++;
                end
            end else begin
                m_idx++;
            end
        end else begin
            m_pre++;
        end
    endtask

    task automatic step(string tag);
        exp_t e;
        model_edge(e);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk(tag, {15'd0, dig, seg, frame_tick}, {15'd0, e.d, e.s, e.f});
    endtask

    task automatic rst_pulse();
        rstn = 1'b0;
        step("rst");
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] xd;
        logic [7:0] xs;
        int cnt, hi, on;
        logic [7:0] lzs_exp [4];

        rstn       = 1'b0;
        enable     = 1'b1;
        nlit       = 4'd0;
        duty       = 4'd15;
        digits     = 32'h7654_3210;
        dp_in      = 8'h00;
        blank      = 8'h00;
        blink_mask = 8'h00;
        lzs        = 1'b0;
        model_reset();

        repeat (3) step("reset");
        chk("reset_dig", dig, 8'hFF);
        chk("reset_seg", seg, 8'h00);
        rstn = 1'b1;

        // Basic scan, one glyph per slot.
        for (int k = 0; k < 8; k++) begin
            step("scan");
            xd = ~(8'h01 << k);
            xs = {1'b0, GLY[k]};
            chk("scan_dig", dig, xd);
            chk("scan_seg", seg, xs);
            repeat (15) step("scan");
        end
        cnt = 0;
        for (int c = 0; c < 256; c++) begin
            step("scan_ft");
            if (frame_tick) cnt++;
        end
        chk("ft_per_128", cnt, 2);

        // Four active digits: 64-cycle frame, upper selects idle.
        nlit = 4'd4;
        cnt  = 0;
        hi   = 0;
        for (int c = 0; c < 128; c++) begin
            step("nlit4");
            if (frame_tick) cnt++;
            if (dig[7:4] != 4'hF) hi++;
        end
        chk("nlit4_ticks", cnt, 2);
        chk("nlit4_upper", hi, 0);

        // Shrink nlit 8->2 while on digit 5.
        nlit = 4'd0;
        for (int c = 0; c < 200 && !(m_idx == 5 && m_pre == 3); c++)
            step("to_idx5");
        nlit = 4'd2;
        for (int c = 0; c < 40; c++) begin
            step("shrink");
            if (dig != 8'hFF) break;
        end
        chk("shrink_dig0", dig, 8'hFE);
        repeat (40) step("nlit2");

        // Leading-zero suppression and blanking.
        rst_pulse();
        lzs    = 1'b1;
        nlit   = 4'd4;
        digits = 32'h0000_0050;
        lzs_exp = '{8'h00, 8'h6d, 8'h3f, 8'h3f};
        for (int k = 0; k < 4; k++) begin
            step("lzs");
            chk("lzs_seg", seg, lzs_exp[k]);
            xd = (k == 0) ? 8'hFF : ~(8'h01 << k);
            chk("lzs_dig", dig, xd);
            repeat (15) step("lzs");
        end
        digits = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step("lzs0");
            xs = (k == 3) ? 8'h3f : 8'h00;
            chk("lzs0_seg", seg, xs);
            repeat (15) step("lzs0");
        end
        blank = 8'h08;
        for (int k = 0; k < 4; k++) begin
            step("blank");
            chk("blank_dig", dig, 8'hFF);
            repeat (15) step("blank");
        end

        // Blink with decimal point on digit 0.
        lzs   = 1'b0;
        blank = 8'h00;
        rst_pulse();
        nlit       = 4'd2;
        dp_in      = 8'h01;
        blink_mask = 8'h01;
        for (int f = 0; f < 6; f++) begin
            step("blink");
            xs = ((f / 2) % 2 == 0) ? 8'hbf : 8'h00;
            chk("blink_seg", seg, xs);
            repeat (31) step("blink");
        end

        // Brightness: duty 3 gives 4/16, duty 0 gives 1/16.
        dp_in      = 8'h00;
        blink_mask = 8'h00;
        nlit       = 4'd0;
        digits     = 32'h7654_3210;
        rst_pulse();
        duty = 4'd3;
        for (int k = 0; k < 8; k++) begin
            on = 0;
            for (int c = 0; c < 16; c++) begin
                step("duty3");
                if (dig != 8'hFF) on++;
            end
            chk("duty3_on", on, 4);
        end
        duty = 4'd0;
        for (int k = 0; k < 8; k++) begin
            on = 0;
            for (int c = 0; c < 16; c++) begin
                step("duty0");
                if (dig != 8'hFF) on++;
            end
            chk("duty0_on", on, 1);
        end

        // Enable low mid-slot, then resume.
        duty = 4'd15;
        repeat (5) step("pre_en");
        enable = 1'b0;
        step("en_lo");
        chk("en_lo_dig", dig, 8'hFF);
        chk("en_lo_ft", frame_tick, 1'b0);
        repeat (39) step("en_lo");
        enable = 1'b1;
        repeat (200) step("en_hi");

        // Asynchronous reset pulse mid-frame.
        repeat (20) step("pre_rst");
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_dig", dig, 8'hFF);
        chk("arst_seg", seg, 8'h00);
        chk("arst_ft", frame_tick, 1'b0);
        model_reset();
        #1;
        rstn = 1'b1;
        step("post_rst");
        chk("post_rst_dig", dig, 8'hFE);
        repeat (40) step("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
